// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped UART transmitter. It has a DATA push port, a
//               STATUS register, a 16-bit DIVISOR register, a TX FIFO and a
//               start/8-data/stop serialiser. The FIFO is 8 deep when
//               UART_TX_FIFO_EN is defined. Otherwise it is a single holding
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter logic [31:0] BASE_MEMORY     = 32'hFFFF_FFE0,
    parameter logic [31:0] TOP_MEMORY      = 32'hFFFF_FFEB,
    parameter int          DEFAULT_DIVISOR = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memWrite,
    input  logic [3:0]  byteMask,
    output logic [31:0] memReadData,
    output logic        uart_tx
);

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t       r_state, w_state_next;
    logic [15:0]  r_divisor, r_div_lat, r_clk_cnt, w_eff_div;
    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_shift, w_head;
    logic [CW-1:0] r_count;
    logic         r_overflow;
    logic [31:0]  r_rdata;

    // Address decode. Word index relative to the base, so address bits [1:0] drop out.
    logic        w_in_range, w_sel_data, w_sel_status, w_sel_div, w_wr;
    logic [31:0] w_word_idx;
    assign w_in_range   = (memAddress >= BASE_MEMORY) && (memAddress <= TOP_MEMORY);
    assign w_word_idx   = (memAddress >> 2) - (BASE_MEMORY >> 2);
    assign w_sel_data   = w_in_range && (w_word_idx == 32'd0);
    assign w_sel_status = w_in_range && (w_word_idx == 32'd1);
    assign w_sel_div    = w_in_range && (w_word_idx == 32'd2);
    assign w_wr         = memWrite && w_in_range;

    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, memWriteData[31:16], byteMask[3:2]};

    // FIFO control. A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    logic w_push_req, w_push_ok, w_pop, w_full, w_empty, w_busy, w_ovf_clr, w_bit_done;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_req = w_wr && w_sel_data && byteMask[0];
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_ovf_clr  = w_wr && w_sel_status && byteMask[0] && memWriteData[3];
    assign w_busy     = (r_state != ST_IDLE);
    assign w_eff_div  = (r_divisor == 16'd0) ? 16'd1 : r_divisor;
    assign w_bit_done = (r_clk_cnt == r_div_lat - 16'd1);

`ifdef UART_TX_FIFO_EN
    logic [7:0] r_mem [DEPTH];
    logic [2:0] r_wr_ptr, r_rd_ptr;

    // Storage array. It has no reset because occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= memWriteData[7:0];
    end

    // Pointers are 3 bits wide, so they wrap modulo 8 on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 3'd1;
        end
    end
    assign w_head = r_mem[r_rd_ptr];
`else
    logic [7:0] r_hold;

    // Single holding register. A pop in the same cycle reads the old value before it is overwritten.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_hold <= memWriteData[7:0];
    end
    assign w_head = r_hold;
`endif

    // Occupancy count. Full and empty are derived from this count.
    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else if (w_push_ok && !w_pop) r_count <= r_count + CW'(1);
        else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
    end

    // Sticky overflow. A dropped push in the same cycle as a clear takes precedence.
    always_ff @(posedge clk) begin
        if (reset) r_overflow <= 1'b0;
        else if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        else if (w_ovf_clr) r_overflow <= 1'b0;
    end

    // DIVISOR register with byte-lane enables.
    always_ff @(posedge clk) begin
        if (reset) r_divisor <= 16'(DEFAULT_DIVISOR);
        else if (w_wr && w_sel_div) begin
            if (byteMask[0]) r_divisor[7:0]  <= memWriteData[7:0];
            if (byteMask[1]) r_divisor[15:8] <= memWriteData[15:8];
        end
    end

    // Registered read mux. DATA reads and out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (reset)             r_rdata <= 32'd0;
        else if (w_sel_status) r_rdata <= {28'd0, r_overflow, w_empty, w_full, w_busy};
        else if (w_sel_div)    r_rdata <= {16'd0, r_divisor};
        else                   r_rdata <= 32'd0;
    end
    assign memReadData = r_rdata;

    // TX FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic. A pop happens on every frame start, including a STOP->START chain.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE:  if (!w_empty) begin
                          w_state_next = ST_START;
                          w_pop        = 1'b1;
                      end
            ST_START: if (w_bit_done) w_state_next = ST_DATA;
            ST_DATA:  if (w_bit_done && (r_bit_cnt == 3'd7)) w_state_next = ST_STOP;
            ST_STOP:  if (w_bit_done) begin
                          if (!w_empty) begin
                              w_state_next = ST_START;
                              w_pop        = 1'b1;
                          end else begin
                              w_state_next = ST_IDLE;
                          end
                      end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Bit timing and shift datapath. Each frame start loads the byte and freezes the divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_div_lat <= 16'd1;
        end else if (w_pop) begin
            r_shift   <= w_head;
            r_div_lat <= w_eff_div;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_done) begin
                r_clk_cnt <= 16'd0;
                if (r_state == ST_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + 16'd1;
            end
        end
    end

    // Serial line driven from registered state. The line idles high.
    always_comb begin
        uart_tx = 1'b1;
        case (r_state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = r_shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter BASE_MEMORY, default 32'hFFFF_FFE0: first byte address decoded by the block.
REQ-002 The block SHALL have parameter TOP_MEMORY, default 32'hFFFF_FFEB: last byte address decoded by the block, also used by the SoC read mux.
REQ-003 The block SHALL have parameter DEFAULT_DIVISOR, default 16: reset value of DIVISOR, in clocks per bit.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port memAddress, input, 32 bits: CPU bus byte address.
REQ-007 Port memWriteData, input, 32 bits: CPU bus write data.
REQ-008 Port memWrite, input, 1 bit: CPU bus write strobe.
REQ-009 Port byteMask, input, 4 bits: CPU bus byte enables.
REQ-010 Port memReadData, output, 32 bits: registered read data.
REQ-011 Port uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-012 Register map SHALL be: BASE+0 DATA (write-only), BASE+4 STATUS, BASE+8 DIVISOR (16 bits, R/W); address bits [1:0] are ignored within a word.
REQ-013 Accesses outside BASE_MEMORY..TOP_MEMORY SHALL have no effect; memReadData SHALL be 0 for them.
REQ-014 memReadData SHALL be registered: the value for the address presented in cycle N appears in cycle N+1; DATA reads return 0.
REQ-015 STATUS SHALL read {28'b0, overflow, fifo_empty, fifo_full, tx_busy} in bits [3:0].
REQ-016 A write to DATA with memWrite=1 and byteMask[0]=1 SHALL push memWriteData[7:0] into the TX FIFO.
REQ-017 A push while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL set sticky overflow.
REQ-018 A simultaneous push and pop on a full FIFO SHALL accept the push.
REQ-019 Overflow SHALL be cleared by writing STATUS with byteMask[0]=1 and memWriteData[3]=1.
REQ-020 Writes to DIVISOR SHALL honour byteMask[1:0]; a stored value of 0 SHALL behave as 1.
REQ-021 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-022 IDLE->START SHALL occur when the FIFO is non-empty; this transition pops one byte and latches DIVISOR for the whole frame.
REQ-023 START SHALL drive 0, DATA SHALL drive 8 bits LSB first, and STOP SHALL drive 1; each bit lasts exactly the latched divisor clocks.
REQ-024 STOP->START SHALL occur directly if the FIFO is non-empty, otherwise STOP->IDLE; back-to-back frames SHALL have no idle gap.
REQ-025 tx_busy SHALL be 1 in every state except IDLE.
REQ-026 FIFO pointers SHALL wrap modulo depth.
REQ-027 fifo_full and fifo_empty SHALL be derived from an occupancy count, not from pointer equality alone.

Reset
REQ-028 On reset the block SHALL drive uart_tx=1 on the next edge, with FSM=IDLE, FIFO empty, overflow=0, DIVISOR=DEFAULT_DIVISOR, and memReadData=0.
REQ-029 A reset mid-frame SHALL abort the frame and discard FIFO contents; no partial byte resumes.

Configuration
REQ-030 With UART_TX_FIFO_EN defined, the FIFO SHALL be 8 entries deep.
REQ-031 Without UART_TX_FIFO_EN, the FIFO SHALL be a single holding register with the same full/empty/overflow semantics; register map and timing are unchanged.

Verification
REQ-032 Divisor check: reset, DIVISOR=4, write DATA=0x55 -> uart_tx shows start bit, then 1,0,1,0,1,0,1,0, then stop; each bit is 4 clocks; 40 clocks total; tx_busy falls afterwards.
REQ-033 Back-to-back frames: DIVISOR=2, write 0xA5 then 0x3C on consecutive cycles -> two frames with no idle gap, 40 clocks total; STATUS reads 0x4 at the end.
REQ-034 Overflow, UART_TX_FIFO_EN defined, DIVISOR=16: write 10 bytes in 10 cycles -> one byte in flight, 8 queued, 1 dropped; STATUS bit3=1 until STATUS is written with 0x8.
REQ-035 Overflow, UART_TX_FIFO_EN undefined: write 3 bytes back-to-back -> first byte is sent, second is held, third is dropped with overflow=1.
REQ-036 Read latency: read DIVISOR at address 0xFFFF_FFE8 -> 16 appears on memReadData the cycle after; a read of 0x0000_0100 returns 0.
REQ-037 Reset mid-frame: assert reset during DATA bit 3 -> uart_tx=1 next cycle, STATUS=0x4, and no further frames are sent.
